// File: rtl/mem2_wb_stage.sv
// -----------------------------------------------------------------------------
// mem2_wb_stage
//   MEM2 pipeline stage. Captures instruction state from MEM, waits for the
//   DCache load response, then aligns and sign/zero-extends the load data.
//   It drives the registered instruction fields and the selected writeback
//   value to WB, and requests a stall while a load response is outstanding.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   MEM2_Flush          : clear stage contents (priority over MEM2_Wr)
//   MEM2_Wr             : capture enable from the hazard unit
//   MEM_*               : MEM-stage instruction fields (ALUOut = load address)
//   MEM_IsLoad          : instruction expects a DCache read response
//   MEM_LoadType        : 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU (else LW)
//   dc_rdata_valid      : one-cycle DCache read-data-valid pulse
//   dc_rdata            : raw aligned word from DCache
//   MEM2_*              : registered fields presented to WB
//   MEM2_DMOut          : extended load data
//   MEM2_Result         : writeback value selected by MEM2_WbSel
//   MEM2_Busy           : stall request to the hazard unit
// -----------------------------------------------------------------------------
module mem2_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM2_Flush,
  input  logic        MEM2_Wr,
  input  logic [31:0] MEM_PC,
  input  logic [31:0] MEM_Instr,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_OutB,
  input  logic [1:0]  MEM_WbSel,
  input  logic [4:0]  MEM_Dst,
  input  logic [3:0]  MEM_RegsWrType,
  input  logic        MEM_IsLoad,
  input  logic [2:0]  MEM_LoadType,
  input  logic        dc_rdata_valid,
  input  logic [31:0] dc_rdata,
  output logic [31:0] MEM2_PC,
  output logic [31:0] MEM2_Instr,
  output logic [31:0] MEM2_ALUOut,
  output logic [31:0] MEM2_OutB,
  output logic [1:0]  MEM2_WbSel,
  output logic [4:0]  MEM2_Dst,
  output logic [3:0]  MEM2_RegsWrType,
  output logic [31:0] MEM2_DMOut,
  output logic [31:0] MEM2_Result,
  output logic        MEM2_Busy
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] outb_q, outb_d;
  logic [1:0]  wbsel_q, wbsel_d;
  logic [4:0]  dst_q, dst_d;
  logic [3:0]  regswr_q, regswr_d;
  logic [2:0]  ldtype_q, ldtype_d;
  logic [31:0] dmout_q, dmout_d;

  logic        resp;
  logic        capture;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] load_ext;

  // A response only counts while a load is outstanding; late pulses in IDLE
  // (e.g. after a flush) are dropped.
  assign resp      = (state_q == S_WAIT) && dc_rdata_valid;
  assign MEM2_Busy = (state_q == S_WAIT) && !dc_rdata_valid;
  assign capture   = MEM2_Wr && !MEM2_Flush && !MEM2_Busy;

  // Alignment: low address bits come from the registered load address.
  assign byte_sh = dc_rdata >> {aluout_q[1:0], 3'b000};
  assign half_sh = dc_rdata >> {aluout_q[1], 4'b0000};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    load_ext = dc_rdata;
    case (ldtype_q)
      LT_LB:   load_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
      LT_LBU:  load_ext = {24'h0, byte_sh[7:0]};
      LT_LH:   load_ext = {{16{half_sh[15]}}, half_sh[15:0]};
      LT_LHU:  load_ext = {16'h0, half_sh[15:0]};
      default: load_ext = dc_rdata;
    endcase
  end

  // Next-state logic: flush > capture > response latch > hold.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    aluout_d = aluout_q;
    outb_d   = outb_q;
    wbsel_d  = wbsel_q;
    dst_d    = dst_q;
    regswr_d = regswr_q;
    ldtype_d = ldtype_q;
    dmout_d  = dmout_q;

    if (MEM2_Flush) begin
      state_d  = S_IDLE;
      pc_d     = '0;
      instr_d  = '0;
      aluout_d = '0;
      outb_d   = '0;
      wbsel_d  = '0;
      dst_d    = '0;
      regswr_d = '0;
      ldtype_d = '0;
      dmout_d  = '0;
    end else if (capture) begin
      // Capture may coincide with a response: WB takes the result at this
      // same edge, so the new instruction overwrites the stage.
      state_d  = MEM_IsLoad ? S_WAIT : S_IDLE;
      pc_d     = MEM_PC;
      instr_d  = MEM_Instr;
      aluout_d = MEM_ALUOut;
      outb_d   = MEM_OutB;
      wbsel_d  = MEM_WbSel;
      dst_d    = MEM_Dst;
      regswr_d = MEM_RegsWrType;
      ldtype_d = MEM_LoadType;
      dmout_d  = '0;
    end else if (resp) begin
      state_d = S_IDLE;
      dmout_d = load_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      aluout_q <= '0;
      outb_q   <= '0;
      wbsel_q  <= '0;
      dst_q    <= '0;
      regswr_q <= '0;
      ldtype_q <= '0;
      dmout_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates at once at the
      // edge, independent of statement order.
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      aluout_q <= aluout_d;
      outb_q   <= outb_d;
      wbsel_q  <= wbsel_d;
      dst_q    <= dst_d;
      regswr_q <= regswr_d;
      ldtype_q <= ldtype_d;
      dmout_q  <= dmout_d;
    end
  end

  assign MEM2_PC         = pc_q;
  assign MEM2_Instr      = instr_q;
  assign MEM2_ALUOut     = aluout_q;
  assign MEM2_OutB       = outb_q;
  assign MEM2_WbSel      = wbsel_q;
  assign MEM2_Dst        = dst_q;
  assign MEM2_RegsWrType = regswr_q;

  // In the response cycle the extended data bypasses the register so WB can
  // capture it at the same edge it is latched here.
  assign MEM2_DMOut = resp ? load_ext : dmout_q;

  always_comb begin
    MEM2_Result = pc_q + 32'd8;
    case (wbsel_q)
      2'b00:   MEM2_Result = pc_q + 32'd8;
      2'b01:   MEM2_Result = aluout_q;
      2'b10:   MEM2_Result = outb_q;
      default: MEM2_Result = MEM2_DMOut;
    endcase
  end

endmodule

// File: tb/tb_mem2_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem2_wb_stage
//   Directed self-checking bench for mem2_wb_stage. Inputs change 1 ns after
//   the rising edge; outputs are sampled before the next rising edge.
// -----------------------------------------------------------------------------
module tb_mem2_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM2_Flush, MEM2_Wr;
  logic [31:0] MEM_PC, MEM_Instr, MEM_ALUOut, MEM_OutB;
  logic [1:0]  MEM_WbSel;
  logic [4:0]  MEM_Dst;
  logic [3:0]  MEM_RegsWrType;
  logic        MEM_IsLoad;
  logic [2:0]  MEM_LoadType;
  logic        dc_rdata_valid;
  logic [31:0] dc_rdata;
  logic [31:0] MEM2_PC, MEM2_Instr, MEM2_ALUOut, MEM2_OutB;
  logic [1:0]  MEM2_WbSel;
  logic [4:0]  MEM2_Dst;
  logic [3:0]  MEM2_RegsWrType;
  logic [31:0] MEM2_DMOut, MEM2_Result;
  logic        MEM2_Busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem2_wb_stage dut (
    .clk(clk), .rst(rst),
    .MEM2_Flush(MEM2_Flush), .MEM2_Wr(MEM2_Wr),
    .MEM_PC(MEM_PC), .MEM_Instr(MEM_Instr), .MEM_ALUOut(MEM_ALUOut),
    .MEM_OutB(MEM_OutB), .MEM_WbSel(MEM_WbSel), .MEM_Dst(MEM_Dst),
    .MEM_RegsWrType(MEM_RegsWrType), .MEM_IsLoad(MEM_IsLoad),
    .MEM_LoadType(MEM_LoadType),
    .dc_rdata_valid(dc_rdata_valid), .dc_rdata(dc_rdata),
    .MEM2_PC(MEM2_PC), .MEM2_Instr(MEM2_Instr), .MEM2_ALUOut(MEM2_ALUOut),
    .MEM2_OutB(MEM2_OutB), .MEM2_WbSel(MEM2_WbSel), .MEM2_Dst(MEM2_Dst),
    .MEM2_RegsWrType(MEM2_RegsWrType), .MEM2_DMOut(MEM2_DMOut),
    .MEM2_Result(MEM2_Result), .MEM2_Busy(MEM2_Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and capture it at the next edge.
  task automatic issue(input logic [31:0] pc, input logic [31:0] alu,
                       input logic [1:0] wbsel, input logic [4:0] dst,
                       input logic is_load, input logic [2:0] ltype);
    MEM_PC         = pc;
    MEM_Instr      = pc ^ 32'hA5A5_0000;
    MEM_ALUOut     = alu;
    MEM_OutB       = 32'h0BAD_0B0B;
    MEM_WbSel      = wbsel;
    MEM_Dst        = dst;
    MEM_RegsWrType = 4'b1000;
    MEM_IsLoad     = is_load;
    MEM_LoadType   = ltype;
    MEM2_Wr        = 1'b1;
    step();
    MEM2_Wr        = 1'b0;
  endtask

  // Load with a response in the cycle after capture; checks the bypassed data.
  task automatic load_now(input string tag, input logic [31:0] alu,
                          input logic [2:0] ltype, input logic [31:0] raw,
                          input logic [31:0] exp);
    issue(32'h0000_1000, alu, 2'b11, 5'd3, 1'b1, ltype);
    check({tag, "_dm_cleared"}, MEM2_DMOut, 32'h0);
    dc_rdata_valid = 1'b1;
    dc_rdata       = raw;
    #1;
    check({tag, "_dmout"}, MEM2_DMOut, exp);
    check({tag, "_result"}, MEM2_Result, exp);
    step();
    dc_rdata_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    MEM2_Flush = 1'b0; MEM2_Wr = 1'b0;
    MEM_PC = '0; MEM_Instr = '0; MEM_ALUOut = '0; MEM_OutB = '0;
    MEM_WbSel = '0; MEM_Dst = '0; MEM_RegsWrType = '0;
    MEM_IsLoad = 1'b0; MEM_LoadType = '0;
    dc_rdata_valid = 1'b0; dc_rdata = '0;

    // Reset state
    #12;
    check("rst_pc", MEM2_PC, 32'h0);
    check("rst_regswr", {28'h0, MEM2_RegsWrType}, 32'h0);
    check("rst_busy", {31'h0, MEM2_Busy}, 32'h0);
    check("rst_dmout", MEM2_DMOut, 32'h0);
    check("rst_result", MEM2_Result, 32'h8);
    rst = 1'b0;
    step();

    // ALU op
    issue(32'h8000_0000, 32'h0000_1234, 2'b01, 5'd5, 1'b0, 3'b000);
    check("alu_result", MEM2_Result, 32'h1234);
    check("alu_dst", {27'h0, MEM2_Dst}, 32'd5);
    check("alu_busy", {31'h0, MEM2_Busy}, 32'h0);
    check("alu_regswr", {28'h0, MEM2_RegsWrType}, 32'h8);
    check("alu_pc", MEM2_PC, 32'h8000_0000);

    // JAL with PC+8 wrap
    issue(32'hFFFF_FFFC, 32'h0, 2'b00, 5'd31, 1'b0, 3'b000);
    check("jal_wrap", MEM2_Result, 32'h0000_0004);

    // LB, address low bits 11, response three cycles after capture
    issue(32'h0000_0040, 32'h0000_1003, 2'b11, 5'd8, 1'b1, 3'b001);
    check("lb_busy1", {31'h0, MEM2_Busy}, 32'h1);
    step();
    check("lb_busy2", {31'h0, MEM2_Busy}, 32'h1);
    step();
    dc_rdata_valid = 1'b1;
    dc_rdata       = 32'h80AB_CDEF;
    #1;
    check("lb_resp_busy", {31'h0, MEM2_Busy}, 32'h0);
    check("lb_dmout", MEM2_DMOut, 32'hFFFF_FF80);
    check("lb_result", MEM2_Result, 32'hFFFF_FF80);
    step();
    dc_rdata_valid = 1'b0;
    check("lb_latched", MEM2_DMOut, 32'hFFFF_FF80);
    check("lb_idle", {31'h0, MEM2_Busy}, 32'h0);

    // Halfword and other alignment cases
    load_now("lhu", 32'h0000_2002, 3'b100, 32'h9ABC_0000, 32'h0000_9ABC);
    load_now("lh",  32'h0000_2002, 3'b011, 32'h9ABC_0000, 32'hFFFF_9ABC);
    load_now("lh_a0", 32'h0000_2001, 3'b011, 32'h9ABC_7654, 32'h0000_7654);
    load_now("lbu", 32'h0000_2001, 3'b010, 32'h0000_F100, 32'h0000_00F1);
    load_now("lw",  32'h0000_2000, 3'b000, 32'h1234_5678, 32'h1234_5678);
    load_now("lt_other", 32'h0000_2003, 3'b111, 32'h8765_4321, 32'h8765_4321);

    // Hold: MEM2_Wr while busy is ignored until the response arrives
    issue(32'h0000_0100, 32'h0000_3000, 2'b11, 5'd7, 1'b1, 3'b000);
    MEM_PC = 32'h0000_0200; MEM_Dst = 5'd9; MEM_ALUOut = 32'h0000_5555;
    MEM_WbSel = 2'b01; MEM_IsLoad = 1'b0; MEM2_Wr = 1'b1;
    step();
    check("hold_pc1", MEM2_PC, 32'h0000_0100);
    check("hold_dst1", {27'h0, MEM2_Dst}, 32'd7);
    check("hold_busy1", {31'h0, MEM2_Busy}, 32'h1);
    step();
    check("hold_alu2", MEM2_ALUOut, 32'h0000_3000);
    dc_rdata_valid = 1'b1;
    dc_rdata       = 32'hDEAD_BEEF;
    #1;
    check("hold_resp", MEM2_Result, 32'hDEAD_BEEF);
    step();
    dc_rdata_valid = 1'b0;
    MEM2_Wr = 1'b0;
    check("hold_next_pc", MEM2_PC, 32'h0000_0200);
    check("hold_next_res", MEM2_Result, 32'h0000_5555);
    check("hold_next_dm", MEM2_DMOut, 32'h0);

    // Flush in WAIT, then a late response
    issue(32'h0000_0300, 32'h0000_4003, 2'b11, 5'd4, 1'b1, 3'b001);
    check("fl_busy", {31'h0, MEM2_Busy}, 32'h1);
    MEM2_Flush = 1'b1;
    step();
    MEM2_Flush = 1'b0;
    check("fl_pc", MEM2_PC, 32'h0);
    check("fl_busy0", {31'h0, MEM2_Busy}, 32'h0);
    check("fl_regswr", {28'h0, MEM2_RegsWrType}, 32'h0);
    check("fl_result", MEM2_Result, 32'h8);
    step();
    dc_rdata_valid = 1'b1;
    dc_rdata       = 32'hFFFF_FFFF;
    #1;
    check("late_dm_comb", MEM2_DMOut, 32'h0);
    step();
    dc_rdata_valid = 1'b0;
    check("late_dm_reg", MEM2_DMOut, 32'h0);
    check("late_busy", {31'h0, MEM2_Busy}, 32'h0);

    // Flush and response in the same WAIT cycle: flush wins
    issue(32'h0000_0400, 32'h0000_5000, 2'b11, 5'd6, 1'b1, 3'b000);
    dc_rdata_valid = 1'b1;
    dc_rdata       = 32'h5A5A_5A5A;
    MEM2_Flush     = 1'b1;
    step();
    dc_rdata_valid = 1'b0;
    MEM2_Flush     = 1'b0;
    check("flv_dm", MEM2_DMOut, 32'h0);
    check("flv_dst", {27'h0, MEM2_Dst}, 32'h0);

    // Asynchronous reset in WAIT
    issue(32'h0000_0500, 32'h0000_6000, 2'b11, 5'd2, 1'b1, 3'b000);
    check("ar_busy", {31'h0, MEM2_Busy}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_pc", MEM2_PC, 32'h0);
    check("ar_busy0", {31'h0, MEM2_Busy}, 32'h0);
    rst = 1'b0;
    step();
    check("ar_stay_idle", {31'h0, MEM2_Busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
